systolic_array_ctrl: RTL and testbench

//  Sequencer for the NxN int8 systolic array. Takes one A tile and one B tile

---
 rtl/systolic_pkg.sv | 8 +
 rtl/skew_feeder.sv | 24 ++
 rtl/systolic_array_ctrl.sv | 103 ++++++++++
 tb/tb_systolic_array_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// systolic_pkg: shared FSM state, operand type and feed length for the systolic array sequencer
package systolic_pkg;
  localparam int N = 8;
  localparam int DW = 8;
  typedef enum logic [1:0] {S_CLEAR, S_LOAD, S_FEED, S_DRAIN} state_t;
  typedef logic signed [DW-1:0] op_t;
  localparam int FEED_CYC = 3*N-1;
endpackage

// File: rtl/skew_feeder.sv
// skew_feeder: NxN operand buffer; lane l emits the element stored at k=t-l, zero outside the window
module skew_feeder #(
  parameter int N = 8,
  parameter int DW = 8,
  parameter int TW = $clog2(3*N)
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [$clog2(N)-1:0] wr_k,
  input  logic [N-1:0][DW-1:0] wr_data,
  input  logic [TW-1:0]        t,
  output logic [N-1:0][DW-1:0] lane_op
);
  localparam int KW = $clog2(N);
  logic [N-1:0][N-1:0][DW-1:0] mem;
  always_ff @(posedge clk)
    if (wr_en)
      for (int l = 0; l < N; l++) mem[l][wr_k] <= wr_data[l];
  for (genvar l = 0; l < N; l++) begin : g_lane
    logic signed [TW+1:0] d;
    assign d = $signed({2'b00, t}) - $signed((TW+2)'(l));
    assign lane_op[l] = (!d[TW+1] && d < $signed((TW+2)'(N))) ? mem[l][d[KW-1:0]] : '0;
  end
endmodule

// File: rtl/systolic_array_ctrl.sv
// systolic_array_ctrl: loads one A/B tile, feeds the skewed wavefront, presents the result.
// Define SYSTOLIC_ARRAY_CTRL_ACCUM_EN to keep accumulating across K-tiles until i_s_last.
module systolic_array_ctrl #(
  parameter int N = 8,
  parameter int DW = 8
) (
  input  logic                          i_clk,
  input  logic                          i_arst,
  input  logic                          i_s_valid,
  output logic                          o_s_ready,
  input  logic [N-1:0][DW-1:0]          i_s_aCol,
  input  logic [N-1:0][DW-1:0]          i_s_bRow,
  input  logic                          i_s_last,
  output logic                          o_peClr,
  output logic                          o_doProcess,
  output logic [N-1:0][2*N-2:0][DW-1:0] o_row,
  output logic [N-1:0][2*N-2:0][DW-1:0] o_col,
  output logic                          o_m_valid,
  input  logic                          i_m_ready,
  output logic                          o_busy
);
  import systolic_pkg::*;
  localparam int BW = $clog2(N+1);
  localparam int TW = $clog2(3*N);
  localparam int KW = $clog2(N);
  localparam int FC = 3*N-1;
  state_t state;
  logic [BW-1:0] beat;
  logic [TW-1:0] t, t_nxt;
  logic take, load_done, feed_done, feed_nxt, more_k;
  logic [N-1:0][DW-1:0] row_op, col_op;
  assign take = o_s_ready & i_s_valid;
  assign load_done = take && beat == BW'(N-1);
  assign feed_done = state == S_FEED && t == TW'(FC-1);
  assign feed_nxt = load_done || (state == S_FEED && !feed_done);
  // t_nxt is the wavefront index the edge registers will show next cycle
  assign t_nxt = (state == S_FEED && !feed_done) ? t + 1'b1 : '0;
  assign o_busy = !(state == S_LOAD && beat == '0);
`ifdef SYSTOLIC_ARRAY_CTRL_ACCUM_EN
  logic last_q;
  always_ff @(posedge i_clk)
    if (load_done) last_q <= i_s_last;
  assign more_k = !last_q;
`else
  logic unused_last;
  assign unused_last = i_s_last;
  assign more_k = 1'b0;
`endif
  skew_feeder #(.N(N), .DW(DW), .TW(TW)) u_row (
    .clk(i_clk), .wr_en(take), .wr_k(beat[KW-1:0]), .wr_data(i_s_aCol), .t(t_nxt), .lane_op(row_op)
  );
  skew_feeder #(.N(N), .DW(DW), .TW(TW)) u_col (
    .clk(i_clk), .wr_en(take), .wr_k(beat[KW-1:0]), .wr_data(i_s_bRow), .t(t_nxt), .lane_op(col_op)
  );
  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      state <= S_CLEAR;
      beat <= '0;
      t <= '0;
      o_s_ready <= 1'b0;
      o_peClr <= 1'b1;
      o_doProcess <= 1'b0;
      o_m_valid <= 1'b0;
      o_row <= '0;
      o_col <= '0;
    end else begin
      t <= t_nxt;
      o_row <= '0;
      o_col <= '0;
      for (int l = 0; l < N; l++) begin
        o_row[l][0] <= feed_nxt ? row_op[l] : '0;
        o_col[l][0] <= feed_nxt ? col_op[l] : '0;
      end
      case (state)
        S_CLEAR: begin
          state <= S_LOAD;
          o_peClr <= 1'b0;
          o_s_ready <= 1'b1;
        end
        S_LOAD:
          if (load_done) begin
            state <= S_FEED;
            beat <= '0;
            o_s_ready <= 1'b0;
            o_doProcess <= 1'b1;
          end else if (take) beat <= beat + 1'b1;
        S_FEED:
          if (feed_done) begin
            state <= more_k ? S_LOAD : S_DRAIN;
            o_doProcess <= 1'b0;
            o_s_ready <= more_k;
            o_m_valid <= !more_k;
          end
        default:
          if (i_m_ready) begin
            state <= S_CLEAR;
            o_m_valid <= 1'b0;
            o_peClr <= 1'b1;
          end
      endcase
    end
  end
endmodule

// File: tb/tb_systolic_array_ctrl.sv
// tb_systolic_array_ctrl: randomized bench; an output-stationary array model folds the edge streams into C
module tb_systolic_array_ctrl;
  localparam int N = 8;
  localparam int DW = 8;
  localparam int FC = 3*N-1;
  typedef int lane_t[N];
  logic clk = 1'b0, arst = 1'b1, s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b0;
  logic [N-1:0][DW-1:0] a_col = '0, b_row = '0;
  logic s_ready, pe_clr, do_proc, m_valid, busy;
  logic [N-1:0][2*N-2:0][DW-1:0] row, col;
  int tests = 0, fails = 0;
  int A[N][N], B[N][N], acc[N][N];
  lane_t rs[$], cs[$];

  systolic_array_ctrl #(.N(N), .DW(DW)) dut (
    .i_clk(clk), .i_arst(arst), .i_s_valid(s_valid), .o_s_ready(s_ready),
    .i_s_aCol(a_col), .i_s_bRow(b_row), .i_s_last(s_last), .o_peClr(pe_clr),
    .o_doProcess(do_proc), .o_row(row), .o_col(col), .o_m_valid(m_valid),
    .i_m_ready(m_ready), .o_busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // PE(i,j) meets row i sample s with col j sample s+j-i; a tile's stream is folded when doProcess drops
  always @(negedge clk) begin
    if (do_proc === 1'b1) begin
      lane_t r, c;
      for (int l = 0; l < N; l++) begin
        r[l] = $signed(row[l][0]);
        c[l] = $signed(col[l][0]);
      end
      rs.push_back(r);
      cs.push_back(c);
    end else if (rs.size() > 0) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          for (int s = 0; s < rs.size(); s++)
            if (s + j - i >= 0 && s + j - i < cs.size()) acc[i][j] += rs[s][i] * cs[s+j-i][j];
      rs.delete();
      cs.delete();
    end
    if (pe_clr === 1'b1)
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) acc[i][j] = 0;
  end

  function automatic int dot(int i, int j);
    int s = 0;
    for (int k = 0; k < N; k++) s += A[i][k] * B[k][j];
    return s;
  endfunction

  task automatic set_ident();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        A[i][k] = (i == k) ? 1 : 0;
        B[i][k] = (i == k) ? 1 : 0;
      end
  endtask

  task automatic set_rand();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        A[i][k] = int'($urandom_range(0, 255)) - 128;
        B[i][k] = int'($urandom_range(0, 255)) - 128;
      end
  endtask

  task automatic send_tile(input bit toggle, input bit last);
    int k = 0;
    int cyc = 0;
    while (k < N && cyc < 20*N) begin
      bit v, hit;
      v = toggle ? (cyc % 2 == 0) : 1'b1;
      s_valid = v;
      s_last = last;
      for (int l = 0; l < N; l++) begin
        a_col[l] = v ? DW'(A[l][k]) : DW'($urandom);
        b_row[l] = v ? DW'(B[k][l]) : DW'($urandom);
      end
      hit = v && s_ready === 1'b1;
      @(posedge clk);
      #1;
      if (hit) k++;
      cyc++;
    end
    s_valid = 1'b0;
    tests++;
    if (k != N) begin
      fails++;
      $display("FAIL send_tile: %0d beats accepted, want %0d", k, N);
    end
  endtask

  task automatic finish_tile(input int hold, input int scale, input string name);
    int n = 0;
    int bad = 0;
    int bi = 0, bj = 0;
    while (m_valid !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    tests++;
    if (m_valid !== 1'b1) begin
      fails++;
      $display("FAIL %s m_valid: still %b after %0d cycles, want 1", name, m_valid, n);
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      tests++;
      if ({m_valid, s_ready, do_proc, busy} !== 4'b1001) begin
        fails++;
        $display("FAIL %s hold%0d: {m_valid,s_ready,do_proc,busy}=%b want 1001", name, h, {m_valid, s_ready, do_proc, busy});
      end
    end
    @(negedge clk);
    #1;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (acc[i][j] !== scale * dot(i, j)) begin
          if (bad == 0) begin bi = i; bj = j; end
          bad++;
        end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL %s result: %0d wrong, c[%0d][%0d]=%0d want %0d", name, bad, bi, bj, acc[bi][bj], scale * dot(bi, bj));
    end
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    tests++;
    if ({m_valid, pe_clr} !== 2'b01) begin
      fails++;
      $display("FAIL %s handshake: {m_valid,pe_clr}=%b want 01", name, {m_valid, pe_clr});
    end
  endtask

  task automatic test_reset();
    repeat (3) begin @(posedge clk); #1; end
    tests++;
    if ({pe_clr, s_ready, m_valid, do_proc, busy} !== 5'b10001 || row !== '0 || col !== '0) begin
      fails++;
      $display("FAIL reset: {pe_clr,s_ready,m_valid,do_proc,busy}=%b want 10001", {pe_clr, s_ready, m_valid, do_proc, busy});
    end
    arst = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if ({s_ready, pe_clr, busy} !== 3'b100) begin
      fails++;
      $display("FAIL reset_release: {s_ready,pe_clr,busy}=%b want 100", {s_ready, pe_clr, busy});
    end
  endtask

  task automatic test_identity();
    int n = 0;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        A[i][k] = (i == k) ? 1 : 0;
        B[i][k] = i + k;
      end
    send_tile(1'b0, 1'b1);
    while (do_proc === 1'b1 && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
    tests++;
    if (n != FC) begin
      fails++;
      $display("FAIL identity do_proc: high %0d cycles, want %0d", n, FC);
    end
    tests++;
    if (m_valid !== 1'b1) begin
      fails++;
      $display("FAIL identity latency: m_valid=%b after feed, want 1", m_valid);
    end
    finish_tile(0, 1, "identity");
  endtask

  task automatic test_skew(input bit fixed);
    if (fixed)
      for (int i = 0; i < N; i++)
        for (int k = 0; k < N; k++) begin
          A[i][k] = 1;
          B[i][k] = 2;
        end
    else set_rand();
    send_tile(1'b0, 1'b1);
    for (int t = 0; t < FC; t++) begin
      int bad = 0;
      for (int l = 0; l < N; l++) begin
        int er, ec;
        er = (t - l >= 0 && t - l < N) ? A[l][t-l] : 0;
        ec = (t - l >= 0 && t - l < N) ? B[t-l][l] : 0;
        if (row[l][0] !== DW'(er) || col[l][0] !== DW'(ec)) bad++;
        for (int s = 1; s < 2*N-1; s++)
          if (row[l][s] !== '0 || col[l][s] !== '0) bad++;
      end
      if (do_proc !== 1'b1) bad++;
      tests++;
      if (bad != 0) begin
        fails++;
        $display("FAIL skew t=%0d: %0d lanes wrong, row0=%0d col0=%0d do_proc=%b", t, bad, row[0][0], col[0][0], do_proc);
      end
      if (fixed && t == 0) begin
        tests++;
        if (row[0][0] !== 8'd1 || row[1][0] !== 8'd0) begin
          fails++;
          $display("FAIL skew_t0: row[0]=%0d row[1]=%0d want 1 and 0", row[0][0], row[1][0]);
        end
      end
      @(posedge clk);
      #1;
    end
    tests++;
    if ({do_proc, m_valid} !== 2'b01 || row !== '0 || col !== '0) begin
      fails++;
      $display("FAIL skew_tail: {do_proc,m_valid}=%b want 01 with idle buses", {do_proc, m_valid});
    end
    finish_tile(0, 1, fixed ? "skew_fixed" : "skew_rand");
  endtask

  task automatic test_backpressure();
    set_rand();
    m_ready = 1'b1;
    send_tile(1'b1, 1'b1);
    repeat (5) begin @(posedge clk); #1; end
    tests++;
    if ({do_proc, m_valid, s_ready} !== 3'b100) begin
      fails++;
      $display("FAIL early_ready: {do_proc,m_valid,s_ready}=%b want 100", {do_proc, m_valid, s_ready});
    end
    m_ready = 1'b0;
    finish_tile(10, 1, "backpressure");
  endtask

  task automatic test_reset_mid_feed();
    set_rand();
    send_tile(1'b0, 1'b1);
    repeat (10) begin @(posedge clk); #1; end
    arst = 1'b1;
    @(posedge clk);
    #1;
    arst = 1'b0;
    tests++;
    if ({do_proc, pe_clr, s_ready, m_valid, busy} !== 5'b01001 || row !== '0 || col !== '0) begin
      fails++;
      $display("FAIL abort: {do_proc,pe_clr,s_ready,m_valid,busy}=%b want 01001", {do_proc, pe_clr, s_ready, m_valid, busy});
    end
    @(posedge clk);
    #1;
    tests++;
    if (s_ready !== 1'b1) begin
      fails++;
      $display("FAIL abort_release: s_ready=%b want 1", s_ready);
    end
    set_ident();
    send_tile(1'b0, 1'b1);
    finish_tile(0, 1, "after_abort");
  endtask

`ifdef SYSTOLIC_ARRAY_CTRL_ACCUM_EN
  task automatic test_accum();
    int n = 0;
    set_ident();
    send_tile(1'b0, 1'b0);
    while (do_proc === 1'b1 && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
    tests++;
    if ({m_valid, s_ready, pe_clr, busy} !== 4'b0100) begin
      fails++;
      $display("FAIL accum_mid: {m_valid,s_ready,pe_clr,busy}=%b want 0100", {m_valid, s_ready, pe_clr, busy});
    end
    send_tile(1'b0, 1'b1);
    finish_tile(0, 2, "accum");
  endtask
`else
  task automatic test_last_ignored();
    set_rand();
    send_tile(1'b0, 1'b0);
    finish_tile(0, 1, "last_ignored");
  endtask
`endif

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      set_rand();
      send_tile(1'($urandom_range(0, 1)), 1'b1);
      finish_tile(int'($urandom_range(0, 5)), 1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_skew(1'b1);
    test_skew(1'b0);
    test_backpressure();
    test_reset_mid_feed();
`ifdef SYSTOLIC_ARRAY_CTRL_ACCUM_EN
    test_accum();
`else
    test_last_ignored();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
